rx_word_fifo: RTL and testbench

Receive-side elastic buffer directly downstream of the PHY reception path. It accepts the 32-bit unstriped words and their valid qualifier in the `clk_f` domain and stores them in a small circular buffer. The consumer (link/transaction layer) drains the buffer with a pop handshake. It exports occupancy flags for back-pressure and flags dropped words with a sticky overflow error.

---
 rtl/rx_word_fifo.sv | 112 +++++++++++
 tb/tb_rx_word_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_word_fifo.sv
// rx_word_fifo: receive-side elastic buffer between the PHY reception path
// and the link/transaction layer. Circular DEPTH x 32 register array with a
// separate occupancy counter that drives every status flag.
//
// Handshake semantics:
//   - Producer side: valid_in is a push request with no ready return. A push is
//     accepted when the buffer is not full, or when it is full and pop is
//     accepted in the same cycle. A push into a full buffer without a pop is
//     dropped and sets the sticky overflow_err. The producer is expected to
//     throttle on full/almost_full.
//   - Consumer side: pop is a read request. A pop is accepted only when the
//     buffer is not empty. An accepted pop loads data_out on that edge and
//     raises valid_out for exactly the following cycle. There is no
//     fall-through: a word pushed into an empty buffer cannot be popped in the
//     same cycle.
module rx_word_fifo #(
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk_f,
  input  logic                     reset,
  input  logic [31:0]              data_in,
  input  logic                     valid_in,
  input  logic                     pop,
  output logic [31:0]              data_out,
  output logic                     valid_out,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic                     overflow_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_data_out;
  logic          r_valid_out;
  logic          r_overflow;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;

  // Decode flags from the registered count and qualify push/pop requests.
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == CW'(DEPTH));
    w_pop   = pop && !w_empty;
    // At full, a push is only accepted when a pop frees a slot in the same cycle.
    w_push  = valid_in && (!w_full || w_pop);
    w_drop  = valid_in && w_full && !w_pop;
  end

  // Storage array write; contents are not reset since they are don't-care.
  always_ff @(posedge clk_f) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy, read register and sticky overflow.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_valid_out <= w_pop;
      if (w_push) begin
        // Pointer width equals log2(DEPTH), so the increment wraps modulo DEPTH.
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + AW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output drive: all status flags come from the count register.
  always_comb begin
    data_out     = r_data_out;
    valid_out    = r_valid_out;
    count        = r_count;
    empty        = w_empty;
    full         = w_full;
    almost_empty = (r_count <= CW'(AE_LEVEL));
    almost_full  = (r_count >= CW'(AF_LEVEL));
    overflow_err = r_overflow;
  end

endmodule

// File: tb/tb_rx_word_fifo.sv
// Directed testbench for rx_word_fifo (DEPTH=8, AF_LEVEL=6, AE_LEVEL=2).
module tb_rx_word_fifo;

  // ---------------- clock / reset ----------------
  logic        clk_f = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        pop;
  logic [31:0] data_out;
  logic        valid_out;
  logic        empty;
  logic        full;
  logic        almost_empty;
  logic        almost_full;
  logic        overflow_err;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];

  always #5 clk_f = ~clk_f;

  rx_word_fifo #(.DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk_f        (clk_f),
    .reset        (reset),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow_err (overflow_err),
    .count        (count)
  );

  // ---------------- driver tasks ----------------
  // Apply one cycle of stimulus, then settle 1ns past the rising edge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic p);
    valid_in = v;
    data_in  = d;
    pop      = p;
    @(posedge clk_f);
    #1;
    valid_in = 1'b0;
    pop      = 1'b0;
  endtask

  // Pulse reset low between edges and release it between edges.
  task automatic pulse_reset();
    #2;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk_f);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk_f);
    #1;
    checks++;
    if (data_out !== 32'h0 || valid_out !== 1'b0 || count !== 4'd0 || empty !== 1'b1 ||
        almost_empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got dout=%h vld=%b cnt=%0d e=%b ae=%b f=%b af=%b ovf=%b required 0 0 0 1 1 0 0 0",
               data_out, valid_out, count, empty, almost_empty, full, almost_full, overflow_err);
    end
    reset = 1'b1;
    @(posedge clk_f);
    #1;
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 32'(i), 1'b0);
      checks++;
      if (count !== 4'(i) || empty !== 1'b0 || full !== (i == 8) ||
          almost_full !== (i >= 6) || almost_empty !== (i <= 2)) begin
        errors++;
        $display("FAIL fill_%0d: got cnt=%0d e=%b f=%b af=%b ae=%b required cnt=%0d e=0 f=%b af=%b ae=%b",
                 i, count, empty, full, almost_full, almost_empty, i, (i == 8), (i >= 6), (i <= 2));
      end
    end
    cycle(1'b1, 32'hDEADBEEF, 1'b0);
    checks++;
    if (count !== 4'd8 || full !== 1'b1 || overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drop: got cnt=%0d f=%b ovf=%b required cnt=8 f=1 ovf=1", count, full, overflow_err);
    end
    cycle(1'b0, 32'h0, 1'b0);
    checks++;
    if (overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got ovf=%b required 1", overflow_err);
    end
  endtask

  task automatic test_drain_order();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      checks++;
      if (valid_out !== 1'b1 || data_out !== 32'(i) || count !== 4'(8 - i)) begin
        errors++;
        $display("FAIL drain_%0d: got vld=%b dout=%h cnt=%0d required vld=1 dout=%h cnt=%0d",
                 i, valid_out, data_out, count, 32'(i), 8 - i);
      end
    end
    checks++;
    if (empty !== 1'b1 || overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: got e=%b ovf=%b required e=1 ovf=1", empty, overflow_err);
    end
    cycle(1'b0, 32'h0, 1'b1);
    checks++;
    if (valid_out !== 1'b0 || data_out !== 32'h8 || count !== 4'd0) begin
      errors++;
      $display("FAIL pop_empty: got vld=%b dout=%h cnt=%0d required vld=0 dout=00000008 cnt=0",
               valid_out, data_out, count);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp;
    pulse_reset();
    checks++;
    if (overflow_err !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL sim_reset: got ovf=%b cnt=%0d required ovf=0 cnt=0", overflow_err, count);
    end
    exp_q.delete();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 32'h100 + 32'(i), 1'b0);
      exp_q.push_back(32'h100 + 32'(i));
    end
    // Push and pop together while full.
    cycle(1'b1, 32'hA5A5A5A5, 1'b1);
    exp = exp_q.pop_front();
    exp_q.push_back(32'hA5A5A5A5);
    checks++;
    if (count !== 4'd8 || full !== 1'b1 || overflow_err !== 1'b0 || valid_out !== 1'b1 || data_out !== exp) begin
      errors++;
      $display("FAIL full_push_pop: got cnt=%0d f=%b ovf=%b vld=%b dout=%h required cnt=8 f=1 ovf=0 vld=1 dout=%h",
               count, full, overflow_err, valid_out, data_out, exp);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (valid_out !== 1'b1 || data_out !== exp) begin
        errors++;
        $display("FAIL full_drain_%0d: got vld=%b dout=%h required vld=1 dout=%h", i, valid_out, data_out, exp);
      end
    end
    // Push and pop together while empty: pop ignored, no fall-through.
    cycle(1'b1, 32'h00000077, 1'b1);
    checks++;
    if (valid_out !== 1'b0 || count !== 4'd1 || data_out !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL empty_push_pop: got vld=%b cnt=%0d dout=%h required vld=0 cnt=1 dout=a5a5a5a5",
               valid_out, count, data_out);
    end
    cycle(1'b0, 32'h0, 1'b1);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h77 || count !== 4'd0) begin
      errors++;
      $display("FAIL empty_push_pop_read: got vld=%b dout=%h cnt=%0d required vld=1 dout=00000077 cnt=0",
               valid_out, data_out, count);
    end
  endtask

  task automatic test_wrap_around();
    int          model_cnt;
    int          next_val;
    logic        do_push;
    logic        do_pop;
    logic [31:0] exp;
    exp_q.delete();
    model_cnt = 0;
    next_val  = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'(next_val), 1'b0);
      exp_q.push_back(32'(next_val));
      next_val++;
      model_cnt++;
    end
    // Pattern per 3 cycles: push+pop, push only, pop only -> count 4,5,4.
    for (int k = 0; k < 20; k++) begin
      do_push = (k % 3) != 2;
      do_pop  = (k % 3) != 1;
      cycle(do_push, 32'(next_val), do_pop);
      exp = 32'h0;
      if (do_pop) begin
        exp = exp_q.pop_front();
        model_cnt--;
      end
      if (do_push) begin
        exp_q.push_back(32'(next_val));
        next_val++;
        model_cnt++;
      end
      checks++;
      if (count !== 4'(model_cnt) || valid_out !== do_pop || (do_pop && data_out !== exp)) begin
        errors++;
        $display("FAIL wrap_%0d: got cnt=%0d vld=%b dout=%h required cnt=%0d vld=%b dout=%h",
                 k, count, valid_out, data_out, model_cnt, do_pop, exp);
      end
    end
    while (exp_q.size() > 0) begin
      cycle(1'b0, 32'h0, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (valid_out !== 1'b1 || data_out !== exp) begin
        errors++;
        $display("FAIL wrap_drain: got vld=%b dout=%h required vld=1 dout=%h", valid_out, data_out, exp);
      end
    end
    checks++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL wrap_empty: got e=%b cnt=%0d required e=1 cnt=0", empty, count);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'hC0DE0000 + 32'(i), 1'b0);
    end
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL mid_prefill: got cnt=%0d required 5", count);
    end
    // Assert reset between edges; outputs must clear without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || valid_out !== 1'b0 || data_out !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got cnt=%0d e=%b ae=%b vld=%b dout=%h required cnt=0 e=1 ae=1 vld=0 dout=0",
               count, empty, almost_empty, valid_out, data_out);
    end
    #1;
    reset = 1'b1;
    @(posedge clk_f);
    #1;
    cycle(1'b1, 32'h12345678, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h12345678 || count !== 4'd0) begin
      errors++;
      $display("FAIL post_reset_pop: got vld=%b dout=%h cnt=%0d required vld=1 dout=12345678 cnt=0",
               valid_out, data_out, count);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    reset    = 1'b0;
    valid_in = 1'b0;
    pop      = 1'b0;
    data_in  = 32'h0;
    test_reset();
    test_fill_overflow();
    test_drain_order();
    test_simultaneous();
    test_wrap_around();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
